// File: rtl/ir_hit_decoder_if.sv
// APB3 slave-side signal bundle for ir_hit_decoder.
// The firmware-facing bus master drives the request half; the decoder answers with PRDATA/PREADY/PSLVERR.
interface ir_hit_decoder_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ir_hit_decoder.sv
// Pulse-width IR hit-frame decoder with APB3 register access and a level interrupt.
// Optional IR_OWN_ID_FILTER_EN adds an OWN_ID register at 0x0C that suppresses hits carrying our own ID.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge
// S_HDR   | inside the first mark, waiting to classify it as a header
// S_SPACE | inside an inter-bit space, bounded by 2 units
// S_MARK  | inside a data mark, classified on its rising edge
// S_DONE  | one cycle: publish the decoded ID
// S_ERR   | one cycle: flag a framing error
module ir_hit_decoder #(
  parameter int unsigned UNIT_CYC = 24000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  ir_hit_decoder_if.slave   apb,
  input  logic              hit_data,
  output logic              FABINT
);

  localparam logic [31:0] L0_MIN    = 32'((UNIT_CYC) / 2);
  localparam logic [31:0] L1_MIN    = 32'((3 * UNIT_CYC) / 2);
  localparam logic [31:0] L1_MAX    = 32'((5 * UNIT_CYC) / 2);
  localparam logic [31:0] HDR_MIN   = 32'((7 * UNIT_CYC) / 2);
  localparam logic [31:0] HDR_MAX   = 32'((9 * UNIT_CYC) / 2);
  localparam logic [31:0] SPACE_MAX = 32'(2 * UNIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SPACE, S_MARK, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    CL_ZERO, CL_ONE, CL_HDR, CL_ERR
  } mclass_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d, irq_en_q, irq_en_d;
  logic             fabint_q, fabint_d;
`ifdef IR_OWN_ID_FILTER_EN
  logic [7:0]       own_id_q, own_id_d;
`endif

  logic        fall, rise, cnt_sat;
  logic [31:0] seg_len;
  mclass_t     mclass;
  logic        done_pulse, err_pulse, own_match, accept;
  logic        wr_en;
  logic [1:0]  reg_addr;
  logic [31:0] prdata;
  logic        unused_ok;

  // prev_q holds the previous synchronised level; edges are seen one cycle after s2_q changes
  assign fall     = prev_q & ~s2_q;
  assign rise     = ~prev_q & s2_q;
  assign cnt_sat  = &cnt_q;
  // cnt clears on the edge, so the segment length including the current cycle is cnt + 1
  assign seg_len  = 32'(cnt_q) + 32'd1;
  assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign reg_addr = apb.PADDR[3:2];

`ifdef IR_OWN_ID_FILTER_EN
  assign own_match = (shreg_q == own_id_q);
`else
  assign own_match = 1'b0;
`endif
  assign accept = done_pulse & ~own_match;

  always_comb begin : conditioning
    s1_d   = hit_data;
    s2_d   = s1_q;
    prev_d = s2_q;
    if (fall || rise) begin
      cnt_d = '0;
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin : classify
    mclass = CL_ERR;
    if (!cnt_sat) begin
      if (seg_len >= L0_MIN && seg_len < L1_MIN) begin
        mclass = CL_ZERO;
      end else if (seg_len >= L1_MIN && seg_len < L1_MAX) begin
        mclass = CL_ONE;
      end else if (seg_len >= HDR_MIN && seg_len < HDR_MAX) begin
        mclass = CL_HDR;
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    if (!en_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall) state_d = S_HDR;
        end
        S_HDR: begin
          if (rise) begin
            if (mclass == CL_HDR) begin
              state_d   = S_SPACE;
              bit_idx_d = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_SPACE: begin
          if (fall) begin
            state_d = S_MARK;
          end else if (seg_len > SPACE_MAX) begin
            state_d = S_ERR;
          end
        end
        S_MARK: begin
          if (rise) begin
            if (mclass == CL_ZERO || mclass == CL_ONE) begin
              shreg_d = {(mclass == CL_ONE), shreg_q[7:1]};
              if (bit_idx_q == 3'd7) begin
                state_d = S_DONE;
              end else begin
                bit_idx_d = bit_idx_q + 3'd1;
                state_d   = S_SPACE;
              end
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_DONE: begin
          done_pulse = 1'b1;
          state_d    = S_IDLE;
        end
        S_ERR: begin
          err_pulse = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin : reg_next
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    fabint_d = irq_en_q & (valid_q | ferr_q);
`ifdef IR_OWN_ID_FILTER_EN
    own_id_d = own_id_q;
    if (wr_en && reg_addr == 2'd3) own_id_d = apb.PWDATA[7:0];
`endif
    if (wr_en) begin
      case (reg_addr)
        2'd0: begin
          if (apb.PWDATA[0]) valid_d = 1'b0;
          if (apb.PWDATA[1]) ovr_d   = 1'b0;
          if (apb.PWDATA[2]) ferr_d  = 1'b0;
        end
        2'd2: begin
          en_d     = apb.PWDATA[0];
          irq_en_d = apb.PWDATA[1];
        end
        default: ;
      endcase
    end
    // hardware sets come last so they win over a same-cycle W1C
    if (accept) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (valid_q) ovr_d = 1'b1;
    end
    if (err_pulse) ferr_d = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q   <= S_IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      fabint_q  <= 1'b0;
`ifdef IR_OWN_ID_FILTER_EN
      own_id_q  <= 8'hFF;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      fabint_q  <= fabint_d;
`ifdef IR_OWN_ID_FILTER_EN
      own_id_q  <= own_id_d;
`endif
    end
  end

  always_comb begin : read_mux
    prdata = 32'h0;
    if (apb.PSEL) begin
      case (reg_addr)
        2'd0: prdata = {29'h0, ferr_q, ovr_q, valid_q};
        2'd1: prdata = {24'h0, data_q};
        2'd2: prdata = {30'h0, irq_en_q, en_q};
`ifdef IR_OWN_ID_FILTER_EN
        2'd3: prdata = {24'h0, own_id_q};
`else
        2'd3: prdata = 32'h0;
`endif
        default: prdata = 32'h0;
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign FABINT      = fabint_q;

  assign unused_ok = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:3]};

endmodule

// File: tb/tb_ir_hit_decoder.sv
// Directed bench for ir_hit_decoder with UNIT_CYC = 10: frame decode, latency, overrun, errors, reset.
module tb_ir_hit_decoder;

  logic PCLK = 1'b0;
  logic PRESERN;
  logic hit_data;
  logic FABINT;
  int   n_pass  = 0;
  int   n_total = 0;

  ir_hit_decoder_if apb_if ();

  ir_hit_decoder #(.UNIT_CYC(10), .CNT_W(18)) dut (
    .PCLK     (PCLK),
    .PRESERN  (PRESERN),
    .apb      (apb_if),
    .hit_data (hit_data),
    .FABINT   (FABINT)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b1;
    apb_if.PADDR   = addr;
    apb_if.PWDATA  = data;
    @(negedge PCLK);
    apb_if.PENABLE = 1'b1;
    @(negedge PCLK);
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    apb_if.PADDR   = addr;
    @(negedge PCLK);
    apb_if.PENABLE = 1'b1;
    #1 data = apb_if.PRDATA;
    @(negedge PCLK);
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
  endtask

  task automatic send_mark(input int n);
    hit_data = 1'b0;
    repeat (n) @(negedge PCLK);
    hit_data = 1'b1;
  endtask

  task automatic send_space(input int n);
    hit_data = 1'b1;
    repeat (n) @(negedge PCLK);
  endtask

  // leaves hit_data high right after the final mark
  task automatic send_frame(input logic [7:0] id);
    send_mark(40);
    for (int i = 0; i < 8; i++) begin
      send_space(10);
      send_mark(id[i] ? 20 : 10);
    end
  endtask

  task automatic frame_settle(input logic [7:0] id);
    send_frame(id);
    repeat (8) @(negedge PCLK);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [31:0] exp_own;
`ifdef IR_OWN_ID_FILTER_EN
    exp_own = 32'hFF;
`else
    exp_own = 32'h0;
`endif
    n_total++;
    if (FABINT !== 1'b0) $display("FAIL reset_fabint got=%b exp=0", FABINT); else n_pass++;
    n_total++;
    if (apb_if.PREADY !== 1'b1 || apb_if.PSLVERR !== 1'b0)
      $display("FAIL reset_ready_err got=%b%b exp=10", apb_if.PREADY, apb_if.PSLVERR);
    else n_pass++;
    n_total++;
    if (apb_if.PRDATA !== 32'h0) $display("FAIL reset_prdata_idle got=%h exp=0", apb_if.PRDATA); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_status got=%h exp=0", rd); else n_pass++;
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_data got=%h exp=0", rd); else n_pass++;
    apb_read(32'h8, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_ctrl got=%h exp=0", rd); else n_pass++;
    apb_read(32'hC, rd);
    n_total++;
    if (rd !== exp_own) $display("FAIL reset_reg0c got=%h exp=%h", rd, exp_own); else n_pass++;
  endtask

  task automatic test_single_frame;
    logic [31:0] rd;
    apb_write(32'h8, 32'h3);
    apb_read(32'h8, rd);
    n_total++;
    if (rd !== 32'h3) $display("FAIL ctrl_readback got=%h exp=3", rd); else n_pass++;
    send_frame(8'hA5);
    // VALID lands on the 4th edge after the final rise, FABINT one edge later
    repeat (4) @(negedge PCLK);
    n_total++;
    if (FABINT !== 1'b0) $display("FAIL single_fabint_early got=%b exp=0", FABINT); else n_pass++;
    @(negedge PCLK);
    n_total++;
    if (FABINT !== 1'b1) $display("FAIL single_fabint_latency got=%b exp=1", FABINT); else n_pass++;
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h000000A5) $display("FAIL single_data got=%h exp=000000a5", rd); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL single_status got=%h exp=1", rd); else n_pass++;
    apb_write(32'h0, 32'h1);
    n_total++;
    if (FABINT !== 1'b1) $display("FAIL w1c_fabint_hold got=%b exp=1", FABINT); else n_pass++;
    @(negedge PCLK);
    n_total++;
    if (FABINT !== 1'b0) $display("FAIL w1c_fabint_drop got=%b exp=0", FABINT); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL w1c_status got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    frame_settle(8'h3C);
    frame_settle(8'h42);
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h42) $display("FAIL ovr_data got=%h exp=42", rd); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h3) $display("FAIL ovr_status got=%h exp=3", rd); else n_pass++;
    apb_write(32'h0, 32'h2);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL ovr_clear_only got=%h exp=1", rd); else n_pass++;
    apb_write(32'h0, 32'h7);
  endtask

  task automatic test_bad_mark;
    logic [31:0] rd;
    send_mark(40);
    for (int i = 0; i < 3; i++) begin
      send_space(10);
      send_mark(10);
    end
    send_space(6);
    send_mark(30);
    repeat (8) @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h4) $display("FAIL badmark_status got=%h exp=4", rd); else n_pass++;
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h42) $display("FAIL badmark_data got=%h exp=42", rd); else n_pass++;
    n_total++;
    if (FABINT !== 1'b1) $display("FAIL badmark_fabint got=%b exp=1", FABINT); else n_pass++;
    apb_write(32'h0, 32'h7);
    frame_settle(8'h01);
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h01) $display("FAIL recover_data got=%h exp=01", rd); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL recover_status got=%h exp=1", rd); else n_pass++;
    apb_write(32'h0, 32'h7);
  endtask

  task automatic test_space_timeout;
    logic [31:0] rd;
    send_mark(40);
    for (int i = 0; i < 5; i++) begin
      send_space(10);
      send_mark(20);
    end
    // space exceeds 2U after ~25 cycles of high line; sample before and after
    repeat (20) @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL timeout_early got=%h exp=0", rd); else n_pass++;
    repeat (8) @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h4) $display("FAIL timeout_ferr got=%h exp=4", rd); else n_pass++;
    apb_write(32'h0, 32'h7);
  endtask

  task automatic test_bad_header;
    logic [31:0] rd;
    send_mark(20);
    repeat (30) @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL badhdr_status got=%h exp=0", rd); else n_pass++;
    send_mark(50);
    repeat (30) @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL longhdr_status got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_enable;
    logic [31:0] rd;
    apb_write(32'h8, 32'h0);
    frame_settle(8'h5A);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL disabled_status got=%h exp=0", rd); else n_pass++;
    apb_write(32'h8, 32'h1);
    frame_settle(8'h5A);
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h5A) $display("FAIL noirq_data got=%h exp=5a", rd); else n_pass++;
    n_total++;
    if (FABINT !== 1'b0) $display("FAIL noirq_fabint got=%b exp=0", FABINT); else n_pass++;
    apb_write(32'h0, 32'h7);
    apb_write(32'h8, 32'h3);
  endtask

  task automatic test_reg0c;
    logic [31:0] rd;
`ifdef IR_OWN_ID_FILTER_EN
    apb_write(32'hC, 32'h11);
    apb_read(32'hC, rd);
    n_total++;
    if (rd !== 32'h11) $display("FAIL ownid_readback got=%h exp=11", rd); else n_pass++;
    frame_settle(8'h11);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL ownid_filtered got=%h exp=0", rd); else n_pass++;
    frame_settle(8'h12);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL ownid_pass_status got=%h exp=1", rd); else n_pass++;
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h12) $display("FAIL ownid_pass_data got=%h exp=12", rd); else n_pass++;
    apb_write(32'h0, 32'h7);
`else
    apb_write(32'hC, 32'hAB);
    apb_read(32'hC, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reg0c_ignored got=%h exp=0", rd); else n_pass++;
`endif
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rd;
    frame_settle(8'h33);
    n_total++;
    if (FABINT !== 1'b1) $display("FAIL pre_reset_fabint got=%b exp=1", FABINT); else n_pass++;
    send_mark(40);
    for (int i = 0; i < 4; i++) begin
      send_space(10);
      send_mark(20);
    end
    send_space(10);
    hit_data = 1'b0;
    repeat (5) @(negedge PCLK);
    PRESERN = 1'b0;
    #1;
    n_total++;
    if (FABINT !== 1'b0) $display("FAIL midreset_fabint got=%b exp=0", FABINT); else n_pass++;
    hit_data = 1'b1;
    @(negedge PCLK);
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL midreset_status got=%h exp=0", rd); else n_pass++;
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL midreset_data got=%h exp=0", rd); else n_pass++;
    apb_read(32'h8, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL midreset_ctrl got=%h exp=0", rd); else n_pass++;
    apb_write(32'h8, 32'h3);
    frame_settle(8'h7E);
    apb_read(32'h4, rd);
    n_total++;
    if (rd !== 32'h7E) $display("FAIL postreset_data got=%h exp=7e", rd); else n_pass++;
    apb_read(32'h0, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL postreset_status got=%h exp=1", rd); else n_pass++;
  endtask

  initial begin
    PRESERN        = 1'b0;
    hit_data       = 1'b1;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    apb_if.PADDR   = 32'h0;
    apb_if.PWDATA  = 32'h0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    test_reset;
    test_single_frame;
    test_overrun;
    test_bad_mark;
    test_space_timeout;
    test_bad_header;
    test_enable;
    test_reg0c;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
